// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a five-stage load/store core.
//
// Purpose
//   Detects load-use hazards between decode and execute. Flushes the younger
//   stages when a branch resolves taken in the memory stage. Freezes the whole
//   pipe while data memory is busy. Latches a sticky timeout error when memory
//   stays busy for MAX_WAIT consecutive cycles; only reset clears that error.
//   All enables and flushes are combinational, so a stall or flush takes
//   effect in the same cycle as the event that causes it.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   id_rn, id_rm          source register fields of the decode instruction
//   id_uses_rm            decode instruction actually reads id_rm
//   ex_memRead, ex_rd     load flag and destination of the execute instruction
//   mem_branch_taken      branch resolved taken in the memory stage
//   mem_busy              data memory cannot complete this cycle
//   pc_en .. ex_mem_en    load enables for the PC and pipeline registers
//   *_flush               pipeline register loads a bubble on the next edge
//   state                 RUN=0, BUBBLE=1, MEM_WAIT=2, ERROR=3
//   timeout_err           sticky memory-timeout flag
//   stall_cnt, flush_cnt  saturating performance counters
//
// Build option
//   HAZARD_CTRL_PERF_EN   when defined, the performance counters are
//                         implemented. When it is undefined, both counters
//                         are tied to zero.
//
// State table
//   state    | meaning
//   RUN      | normal flow; branch, busy and load-use events are all honoured
//   BUBBLE   | one load-use bubble already inserted; load-use is ignored
//   MEM_WAIT | memory busy streak in progress, counted in wait_q
//   ERROR    | memory timeout; pipe frozen until reset

module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_BUBBLE   = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    localparam logic [8:0] MAX_WAIT_C = 9'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
    logic       load_use;
    logic [8:0] wait_sum;

    // XZR (register 31) is never a real producer, so it never hazards.
    assign load_use = ex_memRead && (ex_rd != 5'd31) &&
                      ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));

    // Length of the busy streak including the current cycle.
    assign wait_sum = (state_q == S_MEM_WAIT) ? ({1'b0, wait_q} + 9'd1) : 9'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic. A branch wins over busy so that the flush is never
    // lost. MEM_WAIT with memory ready follows the RUN rules in the same cycle.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        if (state_q == S_ERROR) begin
            state_d = S_ERROR;
            wait_d  = wait_q;
        end else if (mem_branch_taken) begin
            state_d = S_RUN;
        end else if (mem_busy) begin
            wait_d = wait_sum[7:0];
            if (wait_sum >= MAX_WAIT_C) begin
                state_d   = S_ERROR;
                timeout_d = 1'b1;
            end else begin
                state_d = S_MEM_WAIT;
            end
        end else if (load_use && (state_q != S_BUBBLE)) begin
            state_d = S_BUBBLE;
        end else begin
            state_d = S_RUN;
        end
    end

    // Output logic. While reset is asserted, the outputs are forced to the idle
    // pattern, whatever the inputs are.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst_n) begin
            if (state_q == S_ERROR) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end else if (mem_branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (mem_busy) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_flush = 1'b1;
            end else if (load_use && (state_q != S_BUBBLE)) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign timeout_err = timeout_q;

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             branch_evt;

    assign branch_evt = mem_branch_taken && (state_q != S_ERROR);

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (branch_evt && (flush_q != {CNT_W{1'b1}})) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 6;
    localparam int SAT      = (1 << CNT_W) - 1;
`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4:0]       id_rn = '0, id_rm = '0, ex_rd = '0;
    logic             id_uses_rm = 1'b0, ex_memRead = 1'b0;
    logic             mem_branch_taken = 1'b0, mem_busy = 1'b0;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0]       state;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the current busy streak length, whether the previous
    // cycle was a load-use bubble, whether the controller has timed out, and
    // plain event tallies.
    int m_streak = 0;
    bit m_bubble = 0;
    bit m_dead   = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_memRead(ex_memRead), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .state(state), .timeout_err(timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (!PERF) return 0;
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic uses,
                         input logic mr, input logic [4:0] rd, input logic br, input logic busy);
        id_rn = rn; id_rm = rm; id_uses_rm = uses;
        ex_memRead = mr; ex_rd = rd; mem_branch_taken = br; mem_busy = busy;
    endtask

    function automatic logic [7:0] ctl_vec();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
    endfunction

    // One clock: check the outputs for the inputs applied, then advance the model
    // across the clock edge. Called 1 time unit after a rising edge.
    task automatic cyc(input string tag);
        logic [7:0] ectl;
        logic [1:0] est;
        bit lu;
        #2;
        lu = ex_memRead && (ex_rd != 5'd31) &&
             ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
        est = m_dead ? 2'd3 : (m_streak > 0) ? 2'd2 : m_bubble ? 2'd1 : 2'd0;
        if (m_dead)                ectl = 8'b0000_0000;
        else if (mem_branch_taken) ectl = 8'b1111_1110;
        else if (mem_busy)         ectl = 8'b0000_0001;
        else if (lu && !m_bubble)  ectl = 8'b0011_0100;
        else                       ectl = 8'b1111_0000;
        check({tag, ".ctl"},   32'(ctl_vec()), 32'(ectl));
        check({tag, ".state"}, 32'(state), 32'(est));
        check({tag, ".terr"},  32'(timeout_err), 32'(m_dead));
        check({tag, ".stall"}, 32'(stall_cnt), 32'(sat(m_stall)));
        check({tag, ".flush"}, 32'(flush_cnt), 32'(sat(m_flush)));
        @(posedge clk);
        if (ectl[7] == 1'b0) m_stall++;
        if (!m_dead) begin
            if (mem_branch_taken) begin
                m_flush++; m_streak = 0; m_bubble = 0;
            end else if (mem_busy) begin
                m_streak++; m_bubble = 0;
                if (m_streak >= MAX_WAIT) m_dead = 1;
            end else if (lu && !m_bubble) begin
                m_bubble = 1; m_streak = 0;
            end else begin
                m_bubble = 0; m_streak = 0;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse with hazard-provoking inputs held during reset.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        drive(5'd3, 5'd4, 1'b1, 1'b1, 5'd3, $urandom_range(0, 1), 1'b1);
        #1;
        check({tag, ".rst_ctl"},   32'(ctl_vec()), 32'h0F0);
        check({tag, ".rst_state"}, 32'(state), 32'd0);
        check({tag, ".rst_terr"},  32'(timeout_err), 32'd0);
        check({tag, ".rst_cnt"},   32'({stall_cnt, flush_cnt}), 32'd0);
        m_streak = 0; m_bubble = 0; m_dead = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
        check({tag, ".rst_hold"},  32'({ctl_vec(), state}), 32'({8'hF0, 2'd0}));
        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] r [0:3];
        logic       busy_now;
        r[0] = 5'd1; r[1] = 5'd2; r[2] = 5'd3; r[3] = 5'd31;
        @(posedge clk);
        #1;
        do_reset("init");
        cyc("idle");

        // Load-use on Rn: one bubble, then back to RUN.
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        cyc("lu_rn");
        cyc("lu_in_bubble");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("lu_after");

        // Load-use on Rm: only when the decode instruction reads Rm.
        drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        cyc("rm_unused");
        drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        cyc("rm_used");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("rm_after");

        // XZR never hazards.
        drive(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
        cyc("xzr");
        cyc("xzr2");

        // Branch beats load-use; branch beats busy.
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        cyc("br_lu");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        cyc("br_busy");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("br_after");

        // Busy for 4 cycles, then release into a load-use on the same cycle.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("busy4");
        drive(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
        cyc("busy4_drop_lu");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("busy4_after");

        // Reset in the middle of a busy streak: no residual stall.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc("busy_mid");
        do_reset("mid_wait");
        for (int i = 0; i < 2; i++) cyc("post_mid");

        // Timeout: 20 busy cycles, then stay in ERROR long enough to saturate.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc("busy20");
        drive(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) cyc("error_hold");
        do_reset("from_err");
        for (int i = 0; i < 2; i++) cyc("post_err");

        // Random traffic with busy bursts, occasional resets.
        busy_now = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (busy_now) busy_now = ($urandom_range(0, 99) < 90);
            else          busy_now = ($urandom_range(0, 99) < 12);
            drive(r[$urandom_range(0, 3)], r[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), r[$urandom_range(0, 3)],
                  ($urandom_range(0, 9) == 0), busy_now);
            cyc("rand");
            if ($urandom_range(0, 149) == 0 || (m_dead && $urandom_range(0, 19) == 0)) begin
                do_reset("rand_rst");
                busy_now = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
